// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, IF/ID handshake, redirect input, and status.
// The fetch unit takes the master side; memory, decode and branch logic take the slave side.
interface fetch_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      address;
    logic [31:0]      instr;
    logic             id_ready;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output address, if_valid, if_instr, if_pc, halted, fetch_count,
        input  instr, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  address, if_valid, if_instr, if_pc, halted, fetch_count,
        output instr, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, drives the memory address, and holds fetched words
// in a single-entry IF/ID register. Handles stalls, redirect with squash, and halt at program end.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PROG_END = 32'd20,
    parameter int          CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    logic [31:0]      pc;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic [CNT_W-1:0] fetch_count;

    logic can_fetch;
    logic slot_free;
    logic fire;

    // NOTE: continuous assigns carry only combinational decode; all state lives in one always_ff.
    assign can_fetch = (pc < PROG_END);
    assign slot_free = !if_valid || bus.id_ready;
    assign fire      = can_fetch && slot_free && !bus.redirect;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else if (bus.redirect) begin
            // Squash regardless of id_ready; target is forced word-aligned.
            pc       <= {bus.redirect_pc[31:2], 2'b00};
            if_valid <= 1'b0;
        end else if (fire) begin
            if_instr <= bus.instr;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 32'd4;
            if (fetch_count != '1)
                fetch_count <= fetch_count + CNT_W'(1);
        end else if (if_valid && bus.id_ready) begin
            if_valid <= 1'b0;
        end
    end

    // Address comes straight from the register, so it only moves on a clock edge.
    assign bus.address     = pc;
    assign bus.if_valid    = if_valid;
    assign bus.if_instr    = if_instr;
    assign bus.if_pc       = if_pc;
    assign bus.fetch_count = fetch_count;
    assign bus.halted      = !can_fetch && !if_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boot/stall/redirect/halt/reset scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_fetch_unit;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] PROG_END = 32'd20;

    logic clk;
    logic reset;

    fetch_unit_if #(.CNT_W(CNT_W)) bus ();

    fetch_unit #(
        .RESET_PC (32'd0),
        .PROG_END (PROG_END),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] prog [5] = '{32'h5800_0000, 32'h5808_0003, 32'h4000_8000,
                              32'h1000_9000, 32'h0800_0002};

    // Combinational instruction memory; out-of-program reads return a marker value.
    always_comb begin
        bus.instr = 32'hDEAD_BEEF;
        if (bus.address < PROG_END)
            bus.instr = prog[bus.address[4:2]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, one update per clock edge.
    longint unsigned m_pc;
    bit              m_valid;
    logic [31:0]     m_instr;
    longint unsigned m_ipc;
    int              m_cnt;

    task automatic model_edge(input bit rst, input bit rdy, input bit rd, input logic [31:0] rpc);
        if (rst) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
        end else if (rd) begin
            m_pc    = (rpc / 4) * 4;
            m_valid = 0;
        end else if (m_pc < PROG_END && (!m_valid || rdy)) begin
            m_instr = prog[m_pc / 4];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 4) % (64'd1 << 32);
            m_cnt   = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("address",     bus.address,             32'(m_pc));
        check("if_valid",    32'(bus.if_valid),       32'(m_valid));
        check("if_instr",    bus.if_instr,            m_instr);
        check("if_pc",       bus.if_pc,               32'(m_ipc));
        check("halted",      32'(bus.halted),         32'(m_pc >= PROG_END && !m_valid));
        check("fetch_count", 32'(bus.fetch_count),    32'(m_cnt));
    endtask

    // Inputs are applied just after a falling edge, the model steps on the rising edge,
    // and outputs are compared on the next falling edge.
    task automatic step(input bit rst, input bit rdy, input bit rd, input logic [31:0] rpc);
        reset           = rst;
        bus.id_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        model_edge(rst, rdy, rd, rpc);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.id_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
        @(negedge clk);

        // Boot run
        do_reset();
        check("rst_address", bus.address, 32'd0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            check("boot_pc", bus.if_pc, 32'(i * 4));
            check("boot_instr", bus.if_instr, prog[i]);
        end
        step(0, 1, 0, 0);
        check("boot_end_valid", 32'(bus.if_valid), 32'd0);
        check("boot_end_halted", 32'(bus.halted), 32'd1);
        check("boot_end_count", 32'(bus.fetch_count), 32'd5);
        check("boot_end_address", bus.address, 32'd20);

        // Resume from halt
        step(0, 1, 1, 32'd16);
        check("resume_halted", 32'(bus.halted), 32'd0);
        step(0, 1, 0, 0);
        check("resume_pc", bus.if_pc, 32'd16);
        check("resume_instr", bus.if_instr, 32'h0800_0002);
        step(0, 1, 0, 0);
        check("rehalt", 32'(bus.halted), 32'd1);
        check("rehalt_count", 32'(bus.fetch_count), 32'd6);

        // Stall at if_pc = 8
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("stall_pc", bus.if_pc, 32'd8);
            check("stall_instr", bus.if_instr, 32'h4000_8000);
            check("stall_address", bus.address, 32'd12);
            check("stall_count", 32'(bus.fetch_count), 32'd3);
        end
        step(0, 1, 0, 0);
        check("unstall_pc", bus.if_pc, 32'd12);

        // Redirect during stall
        step(0, 0, 1, 32'd4);
        check("rdstall_valid", 32'(bus.if_valid), 32'd0);
        check("rdstall_address", bus.address, 32'd4);
        step(0, 1, 0, 0);
        check("rdstall_pc", bus.if_pc, 32'd4);
        check("rdstall_instr", bus.if_instr, 32'h5808_0003);

        // Redirect coinciding with a fire at pc = 8, unaligned target
        step(0, 1, 1, 32'h0000_000E);
        check("rdfire_count", 32'(bus.fetch_count), 32'd5);
        check("rdfire_address", bus.address, 32'h0000_000C);
        step(0, 1, 0, 0);
        check("rdfire_pc", bus.if_pc, 32'd12);

        // Reset mid-run
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("midrst_address", bus.address, 32'd0);
        check("midrst_valid", 32'(bus.if_valid), 32'd0);
        check("midrst_count", 32'(bus.fetch_count), 32'd0);
        check("midrst_halted", 32'(bus.halted), 32'd0);
        step(0, 1, 0, 0);
        check("refetch_pc", bus.if_pc, 32'd0);

        // Random traffic, with occasional resets in the first part only
        for (int i = 0; i < 600; i++) begin
            bit          r_rst;
            bit          r_rdy;
            bit          r_rd;
            logic [31:0] r_rpc;
            r_rst = (i < 300) && ($urandom_range(0, 49) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rd  = ($urandom_range(0, 5) == 0);
            r_rpc = 32'($urandom_range(0, 27));
            if ($urandom_range(0, 19) == 0)
                r_rpc = $urandom;
            step(r_rst, r_rdy, r_rd, r_rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's byte address. It captures the returned 32-bit instruction into a single-entry IF/ID output register, with a valid/ready handshake toward decode. It also handles stalls, branch/jump redirects with squash, and end-of-program halt.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
PROG_END, 32'd20, first byte address past the program; no fetch is issued at pc >= PROG_END.
CNT_W, 16, width of the fetch counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
address  output  32  byte address to instruction memory; equals pc register.
instr  input  32  instruction word returned by instruction memory (combinational read, valid within the cycle).
id_ready  input  1  decode can accept if_instr this cycle.
redirect  input  1  branch/jump taken; load redirect_pc and squash.
redirect_pc  input  32  redirect target byte address.
if_valid  output  1  if_instr/if_pc hold a valid instruction.
if_instr  output  32  registered instruction to decode.
if_pc  output  32  byte address of if_instr.
halted  output  1  pc >= PROG_END and if_valid == 0.
fetch_count  output  CNT_W  number of fetches accepted since reset; saturating.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: pc = RESET_PC (so address = RESET_PC), if_valid = 0, if_instr = 0, if_pc = 0, fetch_count = 0. halted follows from these (0 unless RESET_PC >= PROG_END).
- Reset priority: reset overrides redirect and all other inputs. Reset mid-operation discards any in-flight instruction.
- Address stability: address is driven only from the pc register. It changes only at a clock edge and is never combinationally derived from inputs.
- Definitions:
  - can_fetch = (pc < PROG_END), unsigned compare.
  - slot_free = !if_valid || id_ready.
  - fire = can_fetch && slot_free && !redirect.
- Priority per cycle: reset > redirect > fire > drain > hold.
- redirect = 1:
  - pc <= {redirect_pc[31:2], 2'b00} (low bits forced to zero).
  - if_valid <= 0 (squash), whatever the state of id_ready.
  - No fetch is accepted; fetch_count is unchanged.
- fire:
  - if_instr <= instr, if_pc <= pc, if_valid <= 1, pc <= pc + 4 (mod 2^32).
  - fetch_count <= fetch_count + 1, saturating at all-ones.
- drain (!fire, if_valid = 1, id_ready = 1, !can_fetch): if_valid <= 0; pc holds.
- hold (if_valid = 1, id_ready = 0, no redirect): pc, if_instr, if_pc and if_valid all hold. address is stable for the whole stall.
- Latency and throughput:
  - First if_valid is asserted on the edge after the first cycle with reset low.
  - With id_ready tied high, one instruction per cycle.
  - Redirect costs one bubble cycle: if_valid is low on the cycle after the redirect, and the target is valid on the following cycle.
- Handshake: decode consumes if_instr on any edge where if_valid && id_ready. if_instr/if_pc must not change while if_valid && !id_ready.
- Halt: halted = (pc >= PROG_END) && !if_valid (combinational from registers). A redirect to an address < PROG_END leaves the halted state and resumes fetching.
- Values of instr returned for pc >= PROG_END are never sampled.

Test Plan:
1. Boot run: reset 2 cycles, then id_ready = 1 with the current boot program in instruction memory.
   -> if_pc 0, 4, 8, 12, 16 on consecutive cycles, with if_instr 0x58000000, 0x58080003, 0x40008000, 0x10009000, 0x08000002.
   -> Next cycle: if_valid = 0, halted = 1, fetch_count = 5, address = 20.
2. Stall: id_ready = 0 for 3 cycles while if_pc = 8.
   -> if_instr = 0x40008000, if_pc = 8 and address = 12 are held; fetch_count stays 3.
   -> id_ready = 1 -> if_pc = 12 on the next edge.
3. Redirect during stall: while if_pc = 12 and id_ready = 0, pulse redirect with redirect_pc = 4.
   -> Next cycle: if_valid = 0, address = 4.
   -> Following cycle: if_pc = 4, if_instr = 0x58080003.
4. Redirect coinciding with fire: id_ready = 1, pc = 8, redirect with redirect_pc = 0x0000000E.
   -> No fetch at 8; fetch_count unchanged; pc = 0x0C; next if_pc = 12.
5. Resume from halt: after scenario 1, redirect with redirect_pc = 16.
   -> halted drops; if_pc = 16, if_instr = 0x08000002; then halted = 1 again and fetch_count = 6.
6. Reset mid-run: assert reset for 1 cycle while if_pc = 8 and if_valid = 1.
   -> After that edge: pc = 0, if_valid = 0, fetch_count = 0, halted = 0.
   -> Refetch begins at address 0.
